// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared 33-bit adder runs 32
// shift-add or restoring shift-subtract steps, then a sign-fix step.
module muldiv_seq #(
  parameter int XLEN       = 32,
  parameter bit EARLY_ZERO = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   op1_q, op2_q;
  logic [XLEN-1:0]   hi, lo, addend;
  logic [4:0]        cnt;
  logic              neg, dz, ovf;
  logic              valid_q, ready_q, busy_q;
  logic [XLEN-1:0]   result_q;

  logic              is_div, is_rem, s1, s2, sign_sel;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     add_a, add_b, add_sum;
  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   quo_n, rem_n, fix_res;

  assign is_div = f3_q[2];
  assign is_rem = f3_q[2] & f3_q[1];

  // Operand signedness and magnitudes, used in PREP only
  always_comb begin
    s1       = op1_q[XLEN-1] & (f3_q == 3'b001 || f3_q == 3'b010 ||
                                f3_q == 3'b100 || f3_q == 3'b110);
    s2       = op2_q[XLEN-1] & (f3_q == 3'b001 || f3_q == 3'b100 ||
                                f3_q == 3'b110);
    mag1     = s1 ? (~op1_q + 1'b1) : op1_q;
    mag2     = s2 ? (~op2_q + 1'b1) : op2_q;
    sign_sel = is_rem ? s1 : (s1 ^ s2);
  end

  // Shared adder: add for multiply, subtract (invert + carry-in) for divide
  always_comb begin
    add_a   = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
    add_b   = is_div ? ~{1'b0, addend} : (lo[0] ? {1'b0, addend} : '0);
    add_sum = add_a + add_b + {{XLEN{1'b0}}, is_div};
  end

  always_comb begin
    prod_n  = neg ? (~{hi, lo} + 1'b1) : {hi, lo};
    quo_n   = neg ? (~lo + 1'b1) : lo;
    rem_n   = neg ? (~hi + 1'b1) : hi;
    fix_res = '0;
    if (!is_div)
      fix_res = (f3_q == 3'b000) ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN];
    else if (dz)
      fix_res = is_rem ? op1_q : '1;
    else if (ovf)
      fix_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else
      fix_res = is_rem ? rem_n : quo_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      f3_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      addend   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else if (i_kill && state != S_IDLE) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          f3_q    <= i_funct3;
          op1_q   <= i_op1;
          op2_q   <= i_op2;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state   <= S_PREP;
        end
        S_PREP: begin
          hi     <= '0;
          lo     <= is_div ? mag1 : mag2;
          addend <= is_div ? mag2 : mag1;
          neg    <= sign_sel;
          dz     <= is_div && (op2_q == '0);
          ovf    <= is_div && !f3_q[0] && (op1_q == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (op2_q == '1);
          cnt    <= 5'd31;
          state  <= (EARLY_ZERO && is_div && op2_q == '0) ? S_FIX : S_ITER;
        end
        S_ITER: begin
          if (!is_div) begin
            hi <= add_sum[XLEN:1];
            lo <= {add_sum[0], lo[XLEN-1:1]};
          end else if (!add_sum[XLEN]) begin
            hi <= add_sum[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= add_a[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: if (i_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV32M results, latency,
// handshake, kill and async reset, plus an EARLY_ZERO=1 instance.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, kill, ready;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;
  logic        valid_ez, ready_ez;
  logic        o_ready_ez, o_valid_ez, o_busy_ez;
  logic [31:0] o_result_ez;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .EARLY_ZERO(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_funct3(funct3), .i_op1(op1), .i_op2(op2), .i_kill(kill),
    .o_valid(o_valid), .i_ready(ready), .o_result(o_result), .o_busy(o_busy)
  );

  muldiv_seq #(.XLEN(32), .EARLY_ZERO(1'b1)) dut_ez (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_ez), .o_ready(o_ready_ez),
    .i_funct3(funct3), .i_op1(op1), .i_op2(op2), .i_kill(1'b0),
    .o_valid(o_valid_ez), .i_ready(ready_ez), .o_result(o_result_ez), .o_busy(o_busy_ez)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request through the accept edge, then scramble the request
  // inputs so any late latching shows up as a wrong result.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f;
    op1    = a;
    op2    = b;
    valid  = 1'b1;
    @(posedge clk); #1;
    valid  = 1'b0;
    funct3 = 3'($urandom);
    op1    = $urandom;
    op2    = $urandom;
  endtask

  task automatic waitResult(output int n);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int n;
    applyStimulus(f, a, b);
    waitResult(n);
    checkOutput({tag, " latency"}, 32'(n), 32'd34);
    checkOutput(tag, o_result, exp);
    consume();
    checkOutput({tag, " ready"}, {o_ready, o_valid, o_busy}, 32'b100);
  endtask

  initial begin
    int   n;
    logic flag;
    rst_n = 1'b0; valid = 1'b0; kill = 1'b0; ready = 1'b0;
    funct3 = '0; op1 = '0; op2 = '0; valid_ez = 1'b0; ready_ez = 1'b1;
    #12;
    checkOutput("reset flags", {o_ready, o_valid, o_busy}, 32'b100);
    checkOutput("reset result", o_result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOp("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    runOp("MULH 7*-3",       3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF);
    runOp("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runOp("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    runOp("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    runOp("REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    runOp("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14);
    runOp("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2);
    runOp("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF);
    runOp("REM 5/0",         3'b110, 32'd5,        32'd0,        32'd5);
    runOp("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    runOp("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);

    // Kill in IDLE alongside a request must not block the accept
    kill = 1'b1;
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2);
    kill = 1'b0;
    waitResult(n);
    checkOutput("DIV -7/2 kill-idle latency", 32'(n), 32'd34);
    checkOutput("DIV -7/2 kill-idle", o_result, 32'hFFFFFFFD);

    // Hold the result under backpressure for 10 cycles
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_result !== 32'hFFFFFFFD || o_ready !== 1'b0 || o_valid !== 1'b1) flag = 1'b0;
    end
    checkOutput("backpressure hold", {31'd0, flag}, 32'd1);
    consume();

    // A request pulsed mid-ITER is ignored
    applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD);
    repeat (10) @(posedge clk);
    #1;
    funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    waitResult(n);
    checkOutput("busy-valid latency", 32'(n + 11), 32'd34);
    checkOutput("busy-valid result", o_result, 32'hFFFFFFEB);
    consume();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy-valid dropped", {o_ready, o_valid, o_busy}, 32'b100);

    // Kill at ITER count 15 (17 edges after accept)
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    flag = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
      if (o_valid) flag = 1'b1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill flags", {o_ready, o_valid, o_busy}, 32'b100);
    checkOutput("kill no valid", {31'd0, flag}, 32'd0);
    runOp("after kill REMU", 3'b111, 32'd100, 32'd7, 32'd2);

    // Async reset mid-ITER, observed between clock edges
    applyStimulus(3'b000, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async reset flags", {o_ready, o_valid, o_busy}, 32'b100);
    checkOutput("async reset result", o_result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp("after reset MUL", 3'b000, 32'd3, 32'd5, 32'd15);

    // EARLY_ZERO instance: divide-by-zero skips the iterations
    funct3 = 3'b100; op1 = 32'd5; op2 = 32'd0; valid_ez = 1'b1;
    @(posedge clk); #1;
    valid_ez = 1'b0;
    n = 0;
    while (!o_valid_ez && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("EZ DIV 5/0 latency", 32'(n), 32'd2);
    checkOutput("EZ DIV 5/0", o_result_ez, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide instructions. These are the operations the single-cycle ALU cannot perform.
- Sits beside the ALU in the execute stage. The core raises a request and stalls until the result handshake completes.
- Uses one 33-bit add/subtract datapath, reused every cycle for 32 shift-add (multiply) or restoring shift-subtract (divide) steps, then a sign-fix step.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- EARLY_ZERO, 0: 1 = divide-by-zero skips ITER (PREP→FIX); 0 = fixed latency for all ops.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request (high only in IDLE).
- i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_op1  input  32  rs1 (multiplicand/dividend).
- i_op2  input  32  rs2 (multiplier/divisor).
- i_kill  input  1  abort the in-flight operation (pipeline flush).
- o_valid  output  1  o_result valid (DONE state).
- i_ready  input  1  consumer accepts the result.
- o_result  output  32  result.
- o_busy  output  1  high in PREP, ITER, FIX, DONE.

Behaviour:
- Reset (async, i_rst_n low): state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_result=0, counter=0, all datapath registers 0. Deassertion is sampled synchronously.
- Accept: i_valid && o_ready at an edge. Capture funct3, op1, op2 and go to PREP.
- PREP (1 cycle):
  - Compute magnitudes: op1 is signed for MULH, MULHSU, DIV, REM; op2 is signed for MULH, DIV, REM.
  - Record result sign: multiply = s1^s2; quotient = s1^s2; remainder = s1.
  - Flag div-by-zero (op2==0) and signed overflow (op1=0x80000000, op2=0xFFFFFFFF, signed div/rem).
  - Load count=31 and go to ITER.
- ITER (32 cycles, count 31→0):
  - Multiply: 64-bit {hi,lo} with lo=|multiplier|. If lo[0], hi33 = hi + |multiplicand|. Then shift {carry,hi,lo} right by 1.
  - Divide: {rem,quo} shifted left by 1, bringing in the next dividend bit. trial = rem − |divisor| (33-bit). If non-negative, rem=trial and quo[0]=1.
  - At count==0 go to FIX.
- FIX (1 cycle): select and negate per the recorded sign, then go to DONE.
  - MUL: low 32 bits of the signed product.
  - MULH/MULHSU/MULHU: high 32 bits. When negating the 64-bit value, the carry from the low word propagates into the high word.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Div-by-zero: quotient = 0xFFFFFFFF; remainder = op1 (unmodified).
  - Overflow: quotient = 0x80000000; remainder = 0.
- DONE: o_valid=1 and o_result is held stable.
  - On i_ready → IDLE; o_ready rises the next cycle.
  - Without i_ready, stay in DONE indefinitely.
- Latency: accept edge to o_valid = 34 cycles (PREP 1 + ITER 32 + FIX 1). With EARLY_ZERO=1 and divide-by-zero, latency is 2 cycles.
- Throughput: at most one operation per 35 cycles; no overlap. A new request is accepted only in IDLE.
- i_kill:
  - Any state except IDLE → IDLE next edge; o_valid is forced low that edge and no result is delivered.
  - Kill in DONE discards an unconsumed result.
  - Kill wins over a simultaneous i_ready.
  - Kill in IDLE is ignored, including when i_valid is also high; the request is still accepted.
- i_valid while busy: ignored (o_ready=0). Request inputs must not be latched outside the accept edge.
- Reset mid-operation: immediate return to the reset values; no partial result is delivered.

Test Plan:
- MUL 7×(−3) (op1=7, op2=0xFFFFFFFD) → o_valid exactly 34 cycles after accept, o_result=0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU op1=0xFFFFFFFF (−1), op2=0xFFFFFFFF → 0xFFFFFFFF; MULH 0x80000000×0x80000000 → 0x40000000.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide-by-zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Overflow: DIV 0x80000000/−1 → 0x80000000; REM → 0. EARLY_ZERO=1 variant → o_valid 2 cycles after accept.
- Backpressure/handshake: hold i_ready=0 for 10 cycles in DONE → o_result stable and o_ready=0 throughout. i_valid pulsed mid-ITER → ignored; the next result still matches the first request.
- i_kill at ITER count 15 → IDLE next cycle, o_valid never asserted, a new request accepted immediately. Async i_rst_n low mid-ITER → outputs at reset values without waiting for a clock edge.
